// File: rtl/irq_arbiter.sv
// Interrupt controller for the shared CPU interrupt line. Source edges set pending
// flags, and the highest-priority eligible flag is offered to the CPU over a req/ack handshake.
module irq_arbiter #(
  parameter int          NUM_SRC   = 8,
  parameter logic [23:0] BASE_ADDR = 24'h2020
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_ce,
  input  logic               bus_write,
  input  logic [23:0]        bus_address_in,
  input  logic [7:0]         bus_data_in,
  output logic [7:0]         bus_data_out,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [1:0]         cpu_level,
  output logic               irq,
  output logic [2:0]         irq_index,
  output logic [1:0]         irq_prio,
  input  logic               irq_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [2*NUM_SRC-1:0] prio_q, prio_d;
  logic [NUM_SRC-1:0]   enable_q, enable_d;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [NUM_SRC-1:0]   src_prev_q;
  logic                 armed_q;
  logic [2:0]           lat_idx_q, lat_idx_d;
  logic [1:0]           lat_prio_q, lat_prio_d;

  logic                 sel_prio_lo, sel_prio_hi, sel_enable, sel_pending;
  logic [NUM_SRC-1:0]   rise, sw_clr, ack_clr, eligible;
  logic                 win_found;
  logic [2:0]           win_idx;
  logic [1:0]           win_prio;

  assign sel_prio_lo = (bus_address_in == BASE_ADDR);
  assign sel_prio_hi = (bus_address_in == BASE_ADDR + 24'd1);
  assign sel_enable  = (bus_address_in == BASE_ADDR + 24'd2);
  assign sel_pending = (bus_address_in == BASE_ADDR + 24'd3);

  // After reset, the first enabled cycle only records a baseline, so a line that is
  // held high through reset is not seen as an edge.
  assign rise = armed_q ? (irq_src & ~src_prev_q) : '0;

  always_comb begin
    bus_data_out = '0;
    if (sel_prio_lo) bus_data_out = prio_q[7:0];
    if (sel_prio_hi) bus_data_out = prio_q[15:8];
    if (sel_enable)  bus_data_out = enable_q;
    if (sel_pending) bus_data_out = pending_q;
  end

  // NOTE: every variable in a combinational block gets a default first; otherwise a
  // path that does not assign it infers a latch.
  always_comb begin
    prio_d   = prio_q;
    enable_d = enable_q;
    sw_clr   = '0;
    if (bus_write) begin
      if (sel_prio_lo) prio_d[7:0]  = bus_data_in;
      if (sel_prio_hi) prio_d[15:8] = bus_data_in;
      if (sel_enable)  enable_d     = bus_data_in;
      if (sel_pending) sw_clr       = bus_data_in;
    end
  end

  // Scan upward and replace the winner only on a strictly higher priority, so a tie
  // goes to the lowest index.
  always_comb begin
    eligible  = '0;
    win_found = 1'b0;
    win_idx   = '0;
    win_prio  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = pending_q[i] & enable_q[i] & (prio_q[2*i +: 2] != 2'd0)
                    & (prio_q[2*i +: 2] > cpu_level);
      if (eligible[i] && (!win_found || prio_q[2*i +: 2] > win_prio)) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
        win_prio  = prio_q[2*i +: 2];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lat_idx_d  = lat_idx_q;
    lat_prio_d = lat_prio_q;
    ack_clr    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d    = ST_REQ;
          lat_idx_d  = win_idx;
          lat_prio_d = win_prio;
        end
      end
      ST_REQ: begin
        if (!eligible[lat_idx_q]) begin
          state_d = ST_IDLE;
        end else if (irq_ack) begin
          ack_clr[lat_idx_q] = 1'b1;
          state_d            = ST_HOLD;
        end
      end
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A new edge overrides both kinds of clear in the same cycle.
  assign pending_d = (pending_q & ~(sw_clr | ack_clr)) | rise;

  // NOTE: sequential state uses non-blocking assignments, so every register samples
  // values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prio_q     <= '0;
      enable_q   <= '0;
      pending_q  <= '0;
      src_prev_q <= '0;
      armed_q    <= 1'b0;
      lat_idx_q  <= '0;
      lat_prio_q <= '0;
    end else if (clk_ce) begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      src_prev_q <= irq_src;
      armed_q    <= 1'b1;
      lat_idx_q  <= lat_idx_d;
      lat_prio_q <= lat_prio_d;
    end
  end

  assign irq       = (state_q == ST_REQ);
  assign irq_index = lat_idx_q;
  assign irq_prio  = lat_prio_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter. Directed scenarios are checked against fixed expectations,
// and a randomized run is checked against a cycle-level behavioural model.
module tb_irq_arbiter;

  localparam logic [23:0] A_PLO  = 24'h2020;
  localparam logic [23:0] A_PHI  = 24'h2021;
  localparam logic [23:0] A_EN   = 24'h2022;
  localparam logic [23:0] A_PEND = 24'h2023;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_ce = 1'b1;
  logic        bus_write = 1'b0;
  logic [23:0] bus_address_in = '0;
  logic [7:0]  bus_data_in = '0;
  logic [7:0]  bus_data_out;
  logic [7:0]  irq_src = '0;
  logic [1:0]  cpu_level = '0;
  logic        irq;
  logic [2:0]  irq_index;
  logic [1:0]  irq_prio;
  logic        irq_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  irq_arbiter #(.NUM_SRC(8), .BASE_ADDR(24'h2020)) dut (
    .clk(clk), .reset(reset), .clk_ce(clk_ce), .bus_write(bus_write),
    .bus_address_in(bus_address_in), .bus_data_in(bus_data_in),
    .bus_data_out(bus_data_out), .irq_src(irq_src), .cpu_level(cpu_level),
    .irq(irq), .irq_index(irq_index), .irq_prio(irq_prio), .irq_ack(irq_ack)
  );

  // Behavioural reference: priorities as an array, flags as bit sets, and the
  // presentation phase as 0 = quiet, 1 = presenting, 2 = forced gap.
  logic [1:0] m_prio [8];
  logic [7:0] m_en, m_pend, m_prev;
  bit         m_armed;
  int         m_phase, m_idx, m_pr;

  function automatic logic [7:0] m_read(input logic [23:0] a);
    logic [7:0] d;
    d = '0;
    if (a == A_PLO) for (int i = 0; i < 4; i++) d[2*i +: 2] = m_prio[i];
    if (a == A_PHI) for (int i = 0; i < 4; i++) d[2*i +: 2] = m_prio[i+4];
    if (a == A_EN)   d = m_en;
    if (a == A_PEND) d = m_pend;
    return d;
  endfunction

  task automatic model_step();
    bit         elig [8];
    int         best, score, widx, wpr;
    logic [7:0] clr, rise;
    if (reset) begin
      for (int i = 0; i < 8; i++) m_prio[i] = 2'd0;
      m_en = 0; m_pend = 0; m_prev = 0; m_armed = 0;
      m_phase = 0; m_idx = 0; m_pr = 0;
      return;
    end
    if (!clk_ce) return;
    best = -1; widx = 0; wpr = 0;
    for (int i = 0; i < 8; i++) begin
      elig[i] = m_pend[i] && m_en[i] && m_prio[i] != 0 && int'(m_prio[i]) > int'(cpu_level);
      score = int'(m_prio[i]) * 8 + (7 - i);
      if (elig[i] && score > best) begin best = score; widx = i; wpr = int'(m_prio[i]); end
    end
    clr = 0;
    case (m_phase)
      0: if (best >= 0) begin m_phase = 1; m_idx = widx; m_pr = wpr; end
      1: if (!elig[m_idx]) m_phase = 0;
         else if (irq_ack) begin clr[m_idx] = 1'b1; m_phase = 2; end
      default: m_phase = 0;
    endcase
    if (bus_write) begin
      if (bus_address_in == A_PLO) for (int i = 0; i < 4; i++) m_prio[i] = bus_data_in[2*i +: 2];
      if (bus_address_in == A_PHI) for (int i = 0; i < 4; i++) m_prio[i+4] = bus_data_in[2*i +: 2];
      if (bus_address_in == A_EN) m_en = bus_data_in;
      if (bus_address_in == A_PEND) clr = clr | bus_data_in;
    end
    rise = m_armed ? (irq_src & ~m_prev) : 8'h00;
    m_pend = (m_pend & ~clr) | rise;
    m_prev = irq_src;
    m_armed = 1;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [23:0] a, input logic [7:0] d);
    bus_write = 1'b1; bus_address_in = a; bus_data_in = d;
    cycle();
    bus_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [23:0] a, output logic [7:0] d);
    bus_address_in = a;
    #1;
    d = bus_data_out;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1; clk_ce = 1'b1;
    cycle(); cycle();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    total++; if (irq_index !== 3'd0) begin bad++; $display("FAIL reset_index: got %0d want 0", irq_index); end
    total++; if (irq_prio !== 2'd0) begin bad++; $display("FAIL reset_prio: got %0d want 0", irq_prio); end
    for (int k = 0; k < 4; k++) begin
      bus_rd(A_PLO + 24'(k), d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_reg%0d: got %h want 00", k, d); end
    end
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_basic();
    logic [7:0] d;
    bus_wr(A_EN, 8'h01); bus_wr(A_PLO, 8'h03); cpu_level = 2'd0;
    irq_src = 8'h01; cycle(); irq_src = 8'h00;
    bus_rd(A_PEND, d);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL basic_pend_set: got %h want 01", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq_early: got %b want 0", irq); end
    cycle();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL basic_irq: got %b want 1", irq); end
    total++; if (irq_index !== 3'd0) begin bad++; $display("FAIL basic_index: got %0d want 0", irq_index); end
    total++; if (irq_prio !== 2'd3) begin bad++; $display("FAIL basic_prio: got %0d want 3", irq_prio); end
    irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
    bus_rd(A_PEND, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL basic_ack_clear: got %h want 00", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_hold: got %b want 0", irq); end
    for (int k = 0; k < 3; k++) begin
      cycle();
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_quiet%0d: got %b want 0", k, irq); end
    end
  endtask

  task automatic test_tie();
    logic [7:0] d;
    bus_wr(A_PLO, 8'h08); bus_wr(A_PHI, 8'h08); bus_wr(A_EN, 8'hFF);
    irq_src = 8'h22; cycle(); irq_src = 8'h00; cycle();
    total++; if (irq !== 1'b1 || irq_index !== 3'd1 || irq_prio !== 2'd2) begin
      bad++; $display("FAIL tie_first: got irq=%b idx=%0d prio=%0d want 1/1/2", irq, irq_index, irq_prio); end
    irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
    bus_rd(A_PEND, d);
    total++; if (d !== 8'h20) begin bad++; $display("FAIL tie_pend_after_ack: got %h want 20", d); end
    cycle(); cycle();
    total++; if (irq !== 1'b1 || irq_index !== 3'd5) begin
      bad++; $display("FAIL tie_second: got irq=%b idx=%0d want 1/5", irq, irq_index); end
    irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
    bus_rd(A_PEND, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL tie_pend_final: got %h want 00", d); end
    cycle(); cycle();
  endtask

  task automatic test_cpu_mask();
    logic [7:0] d;
    bus_wr(A_PLO, 8'h18); cpu_level = 2'd1;
    irq_src = 8'h04; cycle(); irq_src = 8'h00; cycle(); cycle();
    bus_rd(A_PEND, d);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_blocked: got %b want 0", irq); end
    total++; if (d !== 8'h04) begin bad++; $display("FAIL mask_pend: got %h want 04", d); end
    cpu_level = 2'd0; cycle();
    total++; if (irq !== 1'b1 || irq_index !== 3'd2 || irq_prio !== 2'd1) begin
      bad++; $display("FAIL mask_release: got irq=%b idx=%0d prio=%0d want 1/2/1", irq, irq_index, irq_prio); end
    irq_ack = 1'b1; cycle(); irq_ack = 1'b0; cycle();
  endtask

  task automatic test_sw_clear();
    logic [7:0] d;
    bus_wr(A_PLO, 8'hD8);
    irq_src = 8'h08; cycle(); cycle(); irq_src = 8'h00;
    total++; if (irq !== 1'b1 || irq_index !== 3'd3) begin
      bad++; $display("FAIL clr_req: got irq=%b idx=%0d want 1/3", irq, irq_index); end
    bus_wr(A_PEND, 8'h08);
    bus_rd(A_PEND, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL clr_pend: got %h want 00", d); end
    cycle();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL clr_drop: got %b want 0", irq); end
    irq_src = 8'h08; cycle(); cycle(); irq_src = 8'h00; cycle();
    total++; if (irq !== 1'b1 || irq_index !== 3'd3) begin
      bad++; $display("FAIL clr_rereq: got irq=%b idx=%0d want 1/3", irq, irq_index); end
    irq_src = 8'h08; bus_wr(A_PEND, 8'h08);
    bus_rd(A_PEND, d);
    total++; if (d !== 8'h08) begin bad++; $display("FAIL clr_set_wins: got %h want 08", d); end
    cycle();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL clr_irq_stays: got %b want 1", irq); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    irq_src = 8'hFF; reset = 1'b1; cycle();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rstmid_irq: got %b want 0", irq); end
    for (int k = 0; k < 4; k++) begin
      bus_rd(A_PLO + 24'(k), d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL rstmid_reg%0d: got %h want 00", k, d); end
    end
    cycle(); reset = 1'b0;
    cycle(); cycle(); cycle();
    bus_rd(A_PEND, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL rstmid_no_edge: got %h want 00", d); end
    irq_src = 8'h00; cycle();
  endtask

  task automatic test_clk_ce();
    logic [7:0] d;
    clk_ce = 1'b1;
    bus_wr(A_PHI, 8'h03); bus_wr(A_EN, 8'h10);
    clk_ce = 1'b0; irq_src = 8'h10;
    bus_write = 1'b1; bus_address_in = A_EN; bus_data_in = 8'h00;
    cycle(); cycle(); cycle();
    bus_write = 1'b0;
    bus_rd(A_PEND, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL ce_pend_hold: got %h want 00", d); end
    bus_rd(A_EN, d);
    total++; if (d !== 8'h10) begin bad++; $display("FAIL ce_write_ignored: got %h want 10", d); end
    clk_ce = 1'b1; cycle();
    bus_rd(A_PEND, d);
    total++; if (d !== 8'h10) begin bad++; $display("FAIL ce_capture: got %h want 10", d); end
    cycle();
    total++; if (irq !== 1'b1 || irq_index !== 3'd4 || irq_prio !== 2'd3) begin
      bad++; $display("FAIL ce_req: got irq=%b idx=%0d prio=%0d want 1/4/3", irq, irq_index, irq_prio); end
    irq_ack = 1'b1; cycle(); irq_ack = 1'b0;
    cycle(); cycle(); cycle();
    bus_rd(A_PEND, d);
    total++; if (d !== 8'h00 || irq !== 1'b0) begin
      bad++; $display("FAIL ce_once: got pend=%h irq=%b want 00/0", d, irq); end
    irq_src = 8'h00; cycle();
  endtask

  task automatic test_random();
    logic [7:0]  d;
    logic [23:0] a;
    bus_wr(A_PLO, 8'($urandom)); bus_wr(A_PHI, 8'($urandom)); bus_wr(A_EN, 8'hFF);
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      clk_ce    = ($urandom_range(0, 3) != 0);
      irq_src   = irq_src ^ 8'($urandom & $urandom);
      irq_ack   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) cpu_level = 2'($urandom);
      bus_write = ($urandom_range(0, 9) == 0);
      bus_address_in = A_PLO + 24'($urandom_range(0, 4));
      bus_data_in = 8'($urandom);
      cycle();
      bus_write = 1'b0; reset = 1'b0; irq_ack = 1'b0;
      total++; if (irq !== (m_phase == 1)) begin
        bad++; $display("FAIL rand_irq @%0d: got %b want %b", n, irq, m_phase == 1); end
      if (m_phase == 1) begin
        total++; if (int'(irq_index) != m_idx || int'(irq_prio) != m_pr) begin
          bad++; $display("FAIL rand_winner @%0d: got %0d/%0d want %0d/%0d", n, irq_index, irq_prio, m_idx, m_pr); end
      end
      a = A_PLO - 24'd1 + 24'($urandom_range(0, 5));
      bus_rd(a, d);
      total++; if (d !== m_read(a)) begin
        bad++; $display("FAIL rand_read @%0d addr %h: got %h want %h", n, a, d, m_read(a)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_cpu_mask();
    test_sw_clear();
    test_reset_mid();
    test_clk_ce();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
